// File: rtl/adder32.sv
// Registered 32-bit adder: sum/carry_out/overflow of a + b + carry_in, one cycle latency.
// Define ADDER32_CLA_EN to build the carry chain from 4-bit lookahead groups instead of ripple.
module adder32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        overflow
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] s;
  logic [32:0] c;

  assign c[0] = carry_in;

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_bit
      assign g[i] = a[i] & b[i];
      assign p[i] = a[i] ^ b[i];
      assign s[i] = p[i] ^ c[i];
    end
  endgenerate

`ifdef ADDER32_CLA_EN
  // Each group sees only its own carry-in; carries inside a group are flattened lookahead terms.
  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_cla
      logic [3:0] gg;
      logic [3:0] pp;
      logic       cin;
      logic       grp_g;
      logic       grp_p;
      assign gg  = g[4*k +: 4];
      assign pp  = p[4*k +: 4];
      assign cin = c[4*k];
      assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                   | (pp[3] & pp[2] & pp[1] & gg[0]);
      assign grp_p = &pp;
      assign c[4*k+1] = gg[0] | (pp[0] & cin);
      assign c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
      assign c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                      | (pp[2] & pp[1] & pp[0] & cin);
      assign c[4*k+4] = grp_g | (grp_p & cin);
    end
  endgenerate
`else
  generate
    for (i = 0; i < 32; i++) begin : g_ripple
      assign c[i+1] = g[i] | (p[i] & c[i]);
    end
  endgenerate
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= 32'h0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sum       <= s;
      carry_out <= c[32];
      overflow  <= c[32] ^ c[31];
    end
  end

endmodule

// File: tb/tb_adder32.sv
// Scoreboard bench for adder32: driver pushes expected {sum,carry_out,overflow}, monitor pops one edge later.
module tb_adder32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        carry_in;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;

  logic [33:0] exp_q[$];
  int          errors;
  int          checks;

  adder32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: every active edge with an outstanding expectation produces one result
  always @(posedge clk) begin
    logic [33:0] exp_v;
    logic [33:0] act_v;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {sum, carry_out, overflow};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL result: sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 act_v[33:2], act_v[1], act_v[0], exp_v[33:2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                       input logic [31:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a        = va;
    b        = vb;
    carry_in = vc;
    exp_q.push_back({es, ec, eo});
  endtask

  task automatic check_now(input string name, input logic [33:0] exp_v);
    logic [33:0] act_v;
    act_v = {sum, carry_out, overflow};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic drive_model(input logic [31:0] va, input logic [31:0] vb, input logic vc);
    logic [32:0] r;
    logic        ovf;
    r   = {1'b0, va} + {1'b0, vb} + {32'b0, vc};
    ovf = (va[31] == vb[31]) && (r[31] != va[31]);
    drive(va, vb, vc, r[31:0], r[32], ovf);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    carry_in = 1'b0;
    #1;
    check_now("reset_initial", 34'h0);
    a = 32'h1234_5678;
    b = 32'h1;
    @(posedge clk);
    #1;
    check_now("reset_held_edge", 34'h0);

    // release on a falling edge; first vector is captured at the next rising edge
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'h0000_0005; b = 32'h0000_0003; carry_in = 1'b0;
    exp_q.push_back({32'h0000_0008, 1'b0, 1'b0});

    drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    drive(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    drive(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
    drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drive(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    drive(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    drive(32'hDEAD_BEEF, 32'h0000_0011, 1'b1, 32'hDEAD_BF01, 1'b0, 1'b0);

    // let the last result land, then reset asynchronously while sum is nonzero
    @(posedge clk);
    #3;
    check_now("pre_reset_sum", {32'hDEAD_BF01, 1'b0, 1'b0});
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 34'h0);
    @(posedge clk);
    #1;
    check_now("reset_hold", 34'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'h0000_00FF; b = 32'h0000_0001; carry_in = 1'b0;
    exp_q.push_back({32'h0000_0100, 1'b0, 1'b0});

    for (int n = 0; n < 10000; n++) begin
      drive_model($urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // bounded drain of the scoreboard
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder32.md
# adder32

32-bit binary adder with a registered result, used as the arithmetic core behind the chip's input and output register stages. It computes `a + b + carry_in` combinationally from its operand inputs and registers the result on the clock. It presents sum, unsigned carry-out and two's-complement overflow to the wrapper one cycle after the operands are sampled. Inside the full chip path, total latency from pads to pads is 3 cycles: input register, adder register, output register.

## Interface
- Parameters: none. Width is fixed at 32 bits.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a` input 32: first operand. Unsigned or two's-complement.
- `b` input 32: second operand.
- `carry_in` input 1: carry into bit 0.
- `sum` output 32: registered low 32 bits of `a + b + carry_in`.
- `carry_out` output 1: registered carry out of bit 31 (the unsigned overflow).
- `overflow` output 1: registered signed overflow flag.

## Operation
- Combinational 33-bit result R = a + b + carry_in, all operands zero-extended.
- The carry chain is built from 32 explicit full-adder cells in a generate loop:
  - Per-bit generate: g[i] = a[i] & b[i].
  - Per-bit propagate: p[i] = a[i] ^ b[i].
  - Sum bit: s[i] = p[i] ^ c[i].
  - Carry: c[i+1] = g[i] | (p[i] & c[i]).
  - c[0] = carry_in.
- Next-state values:
  - sum_next = s[31:0].
  - carry_out_next = c[32].
  - overflow_next = c[32] ^ c[31]. This is equivalent to: a[31] == b[31] and s[31] != a[31].
- On each rising `clk` with `rst_n` high, `sum`, `carry_out` and `overflow` load their next values together.
- No enable and no handshake. A new operand set is accepted every cycle, giving a throughput of one result per clock.
- Wrap-around: sum is modulo 2^32. Bit 32 appears only on `carry_out`.
- No X-masking. X on any input bit may propagate to the outputs.

## Timing
- Latency is 1 cycle: operands present before rising edge N appear on the outputs after edge N.
- Reset values: `sum` = 32'h0, `carry_out` = 0, `overflow` = 0.
- Reset assertion forces all outputs to their reset values immediately, without waiting for `clk`.
- Reset during operation discards any in-flight result.
- The first valid result is captured at the first rising edge on which `rst_n` is high.
- Reset and clock edge arriving together: reset wins, and outputs stay at zero.
- All outputs come directly from flops. There is no combinational path from inputs to outputs.
- The critical path is the 32-bit carry chain and must close within one clock period.

## Configuration
- Macro `ADDER32_CLA_EN`:
  - Defined: the carry chain is replaced by eight 4-bit carry-lookahead groups.
  - Within each group: group generate = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0; group propagate = &p[3:0].
  - The group carry-ins ripple between groups.
  - Internal carries within a group are computed by lookahead, not ripple.
  - Undefined: the plain ripple chain described in Operation is used.
- Outputs, latency and reset behaviour are bit-identical in both builds.
- The test plan must pass with the macro both defined and undefined.

## Test plan
- Reset: assert `rst_n`=0 mid-run while `sum` ≠ 0 → outputs drop to 0 with no clock edge; the first result appears one edge after release.
- Basic: a=32'h0000_0005, b=32'h0000_0003, cin=0 → next cycle sum=32'h8, cout=0, ovf=0.
- Unsigned wrap: a=32'hFFFF_FFFF, b=32'h0, cin=1 → sum=32'h0, cout=1, ovf=0.
- Positive overflow: a=32'h7FFF_FFFF, b=32'h1, cin=0 → sum=32'h8000_0000, cout=0, ovf=1.
- Negative overflow: a=32'h8000_0000, b=32'h8000_0000, cin=0 → sum=32'h0, cout=1, ovf=1.
- Back-to-back random: 10,000 random (a, b, cin) vectors, one per cycle → each output matches the 33-bit reference model and the overflow formula exactly one cycle later.
